// File: rtl/d_array_sink.sv
// d_array_sink: tracks one token through the five d_array taps; optional err_cnt output via D_ARRAY_SINK_ERRCNT_EN
module d_array_sink #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  input  logic             q4,
  input  logic             q5,
  output logic             busy,
  output logic [2:0]       pos,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] trav_cnt
`ifdef D_ARRAY_SINK_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, WAIT, TRACK, DONE, ERROR} state_t;
  state_t           state_q;
  logic             busy_q, done_q, err_q;
  logic [2:0]       pos_q;
  logic [1:0]       code_q;
  logic [CNT_W-1:0] trav_q;
  logic [7:0]       tcnt_q;
  logic [4:0]       v;
  logic             multi;
  logic [7:0]       tnext;
  logic [1:0]       fault;
`ifdef D_ARRAY_SINK_ERRCNT_EN
  logic [CNT_W-1:0] ecnt_q;
  assign err_cnt = ecnt_q;
`endif
  // classify the sampled taps: 0 = legal, else the error code this sample would raise
  always_comb begin
    v = {q5, q4, q3, q2, q1};
    multi = (v & (v - 5'd1)) != 5'd0;
    tnext = tcnt_q + 8'd1;
    fault = 2'd0;
    if (state_q == WAIT)
      fault = (v == 5'd0) ? ((tnext == 8'(TIMEOUT)) ? 2'd3 : 2'd0) : ((v == 5'd1) ? 2'd0 : 2'd1);
    else if (state_q == TRACK)
      fault = multi ? 2'd1 : (pos_q == 3'd5) ? ((v <= 5'd1) ? 2'd0 : 2'd2)
                                              : ((v == 5'(6'd1 << pos_q)) ? 2'd0 : 2'd2);
  end
  // sequencer with registered outputs; arm low beats every pattern check
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      pos_q   <= 3'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      trav_q  <= '0;
      tcnt_q  <= 8'd0;
`ifdef D_ARRAY_SINK_ERRCNT_EN
      ecnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (arm) begin
          state_q <= WAIT;
          busy_q  <= 1'b1;
          tcnt_q  <= 8'd0;
        end
        WAIT, TRACK: if (!arm) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pos_q   <= 3'd0;
        end else if (fault != 2'd0) begin
          state_q <= ERROR;
          busy_q  <= 1'b0;
          pos_q   <= 3'd0;
          err_q   <= 1'b1;
          if (!err_q) code_q <= fault;
`ifdef D_ARRAY_SINK_ERRCNT_EN
          if (ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
`endif
        end else if (state_q == WAIT) begin
          if (v == 5'd0) tcnt_q <= tnext;
          else begin
            state_q <= TRACK;
            pos_q   <= 3'd1;
          end
        end else if (pos_q == 3'd5) begin
          done_q <= 1'b1;
          trav_q <= trav_q + 1'b1;
          if (v == 5'd0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            pos_q   <= 3'd0;
          end else pos_q <= 3'd1;
        end else pos_q <= pos_q + 3'd1;
        DONE: begin
          state_q <= arm ? WAIT : IDLE;
          busy_q  <= arm;
          tcnt_q  <= 8'd0;
        end
        ERROR: if (!arm) state_q <= IDLE;
`ifdef D_ARRAY_SINK_ERRCNT_EN
        else begin
          state_q <= WAIT;
          busy_q  <= 1'b1;
          tcnt_q  <= 8'd0;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy     = busy_q;
  assign pos      = pos_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign trav_cnt = trav_q;
endmodule
